// File: rtl/rom_stream_loader.sv
// Streams a length-prefixed, XOR-checked program image into the instruction ROM write port,
// holding the CPU in reset until a complete image has been written and verified.
module rom_stream_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] LEN_HI  = 4'd1;
    localparam logic [3:0] LEN_LO  = 4'd2;
    localparam logic [3:0] DATA_HI = 4'd3;
    localparam logic [3:0] DATA_LO = 4'd4;
    localparam logic [3:0] WRITE   = 4'd5;
    localparam logic [3:0] CHK     = 4'd6;
    localparam logic [3:0] DONE    = 4'd7;
    localparam logic [3:0] ERROR   = 4'd8;

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    logic [3:0]            state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            chk_q, chk_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  xfer;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH:0]   count_inc;

    assign in_ready  = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
    assign xfer      = in_valid && in_ready;
    assign len_full  = {len_hi_q, in_data};
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        hi_d     = hi_q;
        chk_d    = chk_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN_HI;
                    count_d = '0;
                    chk_d   = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        // Safe to narrow: the length is known to fit in ADDR_WIDTH+1 bits here.
                        len_d   = len_full[ADDR_WIDTH:0];
                        state_d = (len_full == 16'd0) ? CHK : DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    // Address and data are registered here so they stay put after WRITE.
                    addr_d  = count_q[ADDR_WIDTH-1:0];
                    wdata_d = {hi_q, in_data};
                    chk_d   = chk_q ^ hi_q ^ in_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                count_d = count_inc;
                state_d = (count_inc == len_q) ? CHK : DATA_HI;
            end
            CHK: begin
                if (xfer) begin
                    state_d = (in_data == chk_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            hi_q     <= '0;
            chk_q    <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            chk_q    <= chk_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign rom_we       = (state_q == WRITE);
    assign rom_addr     = addr_q;
    assign rom_wdata    = wdata_q;
    assign cpu_rst      = (state_q != DONE);
    assign busy         = !(state_q inside {IDLE, DONE, ERROR});
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign words_loaded = count_q;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Scoreboard bench for rom_stream_loader: the driver queues expected ROM writes, a negedge
// monitor pops and compares each rom_we pulse.
module tb_rom_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rom_we;
    logic [7:0]  rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int errors = 0;
    int checks = 0;

    logic [23:0] sb[$];     // {addr, data} of expected writes
    logic [15:0] words[$];  // payload of the next frame

    rom_stream_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .rom_we(rom_we),
        .rom_addr(rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_rst(cpu_rst),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %0h@%0h, expected no write", rom_wdata,
                         rom_addr);
            end else begin
                logic [23:0] e;
                e = sb.pop_front();
                if ({rom_addr, rom_wdata} !== e) begin
                    errors++;
                    $display("FAIL rom_write: got %0h@%0h, expected %0h@%0h", rom_wdata,
                             rom_addr, e[15:0], e[23:16]);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int cnt;
        @(negedge clk);
        if (stall) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] n, input logic [7:0] chk, input bit stall);
        pulse_start();
        send_byte(n[15:8], stall);
        send_byte(n[7:0], stall);
        if (n <= 16'd256) begin
            for (int i = 0; i < words.size(); i++) begin
                logic [7:0] a;
                a = i[7:0];
                sb.push_back({a, words[i]});
                send_byte(words[i][15:8], stall);
                send_byte(words[i][7:0], stall);
            end
            send_byte(chk, stall);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input bit exp_done, input logic [8:0] exp_wl);
        int cnt;
        cnt = 0;
        while (!(done || error) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({name, "_error"}, {31'd0, error}, {31'd0, !exp_done});
        check({name, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !exp_done});
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_words"}, {23'd0, words_loaded}, {23'd0, exp_wl});
        check({name, "_pending"}, sb.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] x;
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_rom_we", {31'd0, rom_we}, 32'd0);
        check("rst_words", {23'd0, words_loaded}, 32'd0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        // Nominal frame 00 02 12 34 AB CD 40
        words = '{16'h1234, 16'hABCD};
        run_frame(16'd2, 8'h40, 1'b0);
        wait_end("nominal", 1'b1, 9'd2);

        run_frame(16'd2, 8'hF4, 1'b0);
        wait_end("bad_chk", 1'b0, 9'd2);

        run_frame(16'd2, 8'h40, 1'b1);
        wait_end("stall", 1'b1, 9'd2);

        // Full-capacity image
        words = {};
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] hb, lb;
            hb = i[7:0];
            lb = hb ^ 8'h5A;
            words.push_back({hb, lb});
            x = x ^ hb ^ lb;
        end
        run_frame(16'h0100, x, 1'b0);
        wait_end("full", 1'b1, 9'd256);

        run_frame(16'h0101, 8'h00, 1'b0);
        @(negedge clk);
        wait_end("overflow", 1'b0, 9'd0);
        check("overflow_in_ready", {31'd0, in_ready}, 32'd0);

        words = {};
        run_frame(16'd0, 8'h00, 1'b0);
        wait_end("zero_ok", 1'b1, 9'd0);
        run_frame(16'd0, 8'h01, 1'b0);
        wait_end("zero_bad", 1'b0, 9'd0);

        // Abort a 5-word load after three words
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] a;
            a = i[7:0];
            sb.push_back({a, 16'h1100 + 16'(i)});
            send_byte(8'h11, 1'b0);
            send_byte(8'h00 + 8'(i), 1'b0);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_words", {23'd0, words_loaded}, 32'd0);
        check("abort_pending", sb.size(), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        words = '{16'hBEEF};
        run_frame(16'd1, 8'h51, 1'b0);
        wait_end("reload", 1'b1, 9'd1);

        pulse_start();
        check("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_in_ready", {31'd0, in_ready}, 32'd1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
